// File: rtl/object_centroid_tracker.sv
// object_centroid_tracker
//   Classifies each visible RGB565 pixel against an inclusive per-channel colour window.
//   It accumulates count, coordinate sums and bounding box per frame.
//   At frame end it divides sums by count with a 1-bit/cycle restoring divider and
//   publishes the centroid.
// Ports:
//   clk, aresetn                    pixel clock, async active-low reset
//   pixel_valid/rgb/x/y             pixel stream from the frame-buffer read path
//   centroid_x/y, bbox_*            last published object position and extent
//   match_count, found              last frame's matching pixel count, count >= MIN_COUNT
//   result_valid                    one-cycle pulse when the outputs above update
//   busy                            divider running
//   overrun                         sticky: frame end seen while the divider was running
module object_centroid_tracker #(
    parameter int unsigned COORD_W   = 11,
    parameter int unsigned H_ACT     = 640,
    parameter int unsigned V_ACT     = 480,
    parameter int unsigned R_MIN     = 20,
    parameter int unsigned R_MAX     = 31,
    parameter int unsigned G_MIN     = 0,
    parameter int unsigned G_MAX     = 20,
    parameter int unsigned B_MIN     = 0,
    parameter int unsigned B_MAX     = 10,
    parameter int unsigned MIN_COUNT = 64
) (
    input  logic               clk,
    input  logic               aresetn,
    input  logic               pixel_valid,
    input  logic [15:0]        pixel_rgb,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    output logic [COORD_W-1:0] centroid_x,
    output logic [COORD_W-1:0] centroid_y,
    output logic [COORD_W-1:0] bbox_x_min,
    output logic [COORD_W-1:0] bbox_x_max,
    output logic [COORD_W-1:0] bbox_y_min,
    output logic [COORD_W-1:0] bbox_y_max,
    output logic [18:0]        match_count,
    output logic               found,
    output logic               result_valid,
    output logic               busy,
    output logic               overrun
);
    localparam int unsigned CntW    = 19;
    localparam int unsigned SumW    = 28;
    localparam logic [4:0]  DivLast = 5'd27;

    typedef enum logic [1:0] {StIdle, StDivX, StDivY, StPub} state_e;
    state_e state_q, state_d;

    logic [4:0] px_r, px_b;
    logic [5:0] px_g;
    logic       visible, is_match, frame_end, found_now, snap_found, snap_load;

    assign px_r = pixel_rgb[15:11];
    assign px_g = pixel_rgb[10:5];
    assign px_b = pixel_rgb[4:0];

    // Comparisons are done at 32 bits so full-range windows do not fold to constants.
    assign visible   = pixel_valid && (32'(pixel_x) < H_ACT) && (32'(pixel_y) < V_ACT);
    assign is_match  = visible
                       && (32'(px_r) >= R_MIN) && (32'(px_r) <= R_MAX)
                       && (32'(px_g) >= G_MIN) && (32'(px_g) <= G_MAX)
                       && (32'(px_b) >= B_MIN) && (32'(px_b) <= B_MAX);
    assign frame_end = visible && (32'(pixel_x) == H_ACT - 1) && (32'(pixel_y) == V_ACT - 1);

    // Live accumulators (_n includes this cycle's pixel) and frame snapshot.
    logic [CntW-1:0]    cnt_q, cnt_d, cnt_n, snap_cnt_q, snap_cnt_d;
    logic [SumW-1:0]    sx_q, sx_d, sx_n, sy_q, sy_d, sy_n, snap_sy_q, snap_sy_d;
    logic [COORD_W-1:0] xmin_q, xmin_d, xmin_n, xmax_q, xmax_d, xmax_n;
    logic [COORD_W-1:0] ymin_q, ymin_d, ymin_n, ymax_q, ymax_d, ymax_n;
    logic [COORD_W-1:0] snap_xmin_q, snap_xmin_d, snap_xmax_q, snap_xmax_d;
    logic [COORD_W-1:0] snap_ymin_q, snap_ymin_d, snap_ymax_q, snap_ymax_d;

    // A snapshot is only taken when the divider is free; otherwise the frame is dropped.
    assign snap_load  = frame_end && (state_q == StIdle || state_q == StPub);
    assign found_now  = 32'(cnt_n) >= MIN_COUNT;
    assign snap_found = 32'(snap_cnt_q) >= MIN_COUNT;

    always_comb begin
        cnt_n  = cnt_q;
        sx_n   = sx_q;
        sy_n   = sy_q;
        xmin_n = xmin_q;
        xmax_n = xmax_q;
        ymin_n = ymin_q;
        ymax_n = ymax_q;
        if (is_match) begin
            cnt_n = cnt_q + CntW'(1);
            sx_n  = sx_q + SumW'(pixel_x);
            sy_n  = sy_q + SumW'(pixel_y);
            if (pixel_x < xmin_q) xmin_n = pixel_x;
            if (pixel_x > xmax_q) xmax_n = pixel_x;
            if (pixel_y < ymin_q) ymin_n = pixel_y;
            if (pixel_y > ymax_q) ymax_n = pixel_y;
        end
        cnt_d  = frame_end ? '0 : cnt_n;
        sx_d   = frame_end ? '0 : sx_n;
        sy_d   = frame_end ? '0 : sy_n;
        xmin_d = frame_end ? '1 : xmin_n;
        xmax_d = frame_end ? '0 : xmax_n;
        ymin_d = frame_end ? '1 : ymin_n;
        ymax_d = frame_end ? '0 : ymax_n;
        snap_cnt_d  = snap_load ? cnt_n  : snap_cnt_q;
        snap_sy_d   = snap_load ? sy_n   : snap_sy_q;
        snap_xmin_d = snap_load ? xmin_n : snap_xmin_q;
        snap_xmax_d = snap_load ? xmax_n : snap_xmax_q;
        snap_ymin_d = snap_load ? ymin_n : snap_ymin_q;
        snap_ymax_d = snap_load ? ymax_n : snap_ymax_q;
    end

    // Restoring divider: div_q holds the dividend shifting out and the quotient shifting in.
    logic [SumW-1:0]    div_q, div_d, quo_step;
    logic [CntW-1:0]    rem_q, rem_d, rem_step;
    logic [CntW:0]      trial;
    logic               trial_ge;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [COORD_W-1:0] quo_x_q, quo_x_d;

    assign trial    = {rem_q, div_q[SumW-1]};
    assign trial_ge = trial >= {1'b0, snap_cnt_q};
    // The difference is below the divisor, so the low CntW bits are exact.
    assign rem_step = trial_ge ? (trial[CntW-1:0] - snap_cnt_q) : trial[CntW-1:0];
    assign quo_step = {div_q[SumW-2:0], trial_ge};

    // Output registers.
    logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [COORD_W-1:0] oxmin_q, oxmin_d, oxmax_q, oxmax_d, oymin_q, oymin_d, oymax_q, oymax_d;
    logic [CntW-1:0]    ocnt_q, ocnt_d;
    logic               found_q, found_d, rv_q, rv_d, overrun_q, overrun_d;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        rem_d     = rem_q;
        bit_cnt_d = bit_cnt_q;
        quo_x_d   = quo_x_q;
        overrun_d = overrun_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        oxmin_d   = oxmin_q;
        oxmax_d   = oxmax_q;
        oymin_d   = oymin_q;
        oymax_d   = oymax_q;
        ocnt_d    = ocnt_q;
        found_d   = found_q;
        rv_d      = 1'b0;
        unique case (state_q)
            StIdle, StPub: begin
                if (state_q == StPub) begin
                    found_d = snap_found;
                    ocnt_d  = snap_cnt_q;
                    oxmin_d = snap_xmin_q;
                    oxmax_d = snap_xmax_q;
                    oymin_d = snap_ymin_q;
                    oymax_d = snap_ymax_q;
                    rv_d    = 1'b1;
                    if (snap_found) begin
                        cx_d = quo_x_q;
                        cy_d = div_q[COORD_W-1:0];
                    end
                    state_d = StIdle;
                end
                if (frame_end) begin
                    if (found_now) begin
                        state_d   = StDivX;
                        div_d     = sx_n;
                        rem_d     = '0;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = StPub;
                    end
                end
            end
            StDivX, StDivY: begin
                div_d     = quo_step;
                rem_d     = rem_step;
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (frame_end) overrun_d = 1'b1;
                if (bit_cnt_q == DivLast) begin
                    bit_cnt_d = '0;
                    if (state_q == StDivX) begin
                        quo_x_d = quo_step[COORD_W-1:0];
                        div_d   = snap_sy_q;
                        rem_d   = '0;
                        state_d = StDivY;
                    end else begin
                        state_d = StPub;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q       <= '0;
            sx_q        <= '0;
            sy_q        <= '0;
            xmin_q      <= '1;
            xmax_q      <= '0;
            ymin_q      <= '1;
            ymax_q      <= '0;
            snap_cnt_q  <= '0;
            snap_sy_q   <= '0;
            snap_xmin_q <= '1;
            snap_xmax_q <= '0;
            snap_ymin_q <= '1;
            snap_ymax_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
            snap_cnt_q  <= snap_cnt_d;
            snap_sy_q   <= snap_sy_d;
            snap_xmin_q <= snap_xmin_d;
            snap_xmax_q <= snap_xmax_d;
            snap_ymin_q <= snap_ymin_d;
            snap_ymax_q <= snap_ymax_d;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= StIdle;
            div_q     <= '0;
            rem_q     <= '0;
            bit_cnt_q <= '0;
            quo_x_q   <= '0;
            overrun_q <= 1'b0;
            cx_q      <= '0;
            cy_q      <= '0;
            oxmin_q   <= '0;
            oxmax_q   <= '0;
            oymin_q   <= '0;
            oymax_q   <= '0;
            ocnt_q    <= '0;
            found_q   <= 1'b0;
            rv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            rem_q     <= rem_d;
            bit_cnt_q <= bit_cnt_d;
            quo_x_q   <= quo_x_d;
            overrun_q <= overrun_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            oxmin_q   <= oxmin_d;
            oxmax_q   <= oxmax_d;
            oymin_q   <= oymin_d;
            oymax_q   <= oymax_d;
            ocnt_q    <= ocnt_d;
            found_q   <= found_d;
            rv_q      <= rv_d;
        end
    end

    assign centroid_x   = cx_q;
    assign centroid_y   = cy_q;
    assign bbox_x_min   = oxmin_q;
    assign bbox_x_max   = oxmax_q;
    assign bbox_y_min   = oymin_q;
    assign bbox_y_max   = oymax_q;
    assign match_count  = ocnt_q;
    assign found        = found_q;
    assign result_valid = rv_q;
    assign busy         = (state_q == StDivX) || (state_q == StDivY);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_object_centroid_tracker.sv
// Scoreboard bench: frame-end stimulus pushes the hand-computed result; a negedge monitor pops
// and compares whenever result_valid is seen, including the publish cycle.
module tb_object_centroid_tracker;
    localparam logic [15:0] Red   = 16'hF800;
    localparam logic [15:0] Black = 16'h0000;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        pixel_valid = 1'b0;
    logic [15:0] pixel_rgb = '0;
    logic [10:0] pixel_x = '0, pixel_y = '0;
    logic [10:0] centroid_x, centroid_y, bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;
    logic [18:0] match_count;
    logic        found, result_valid, busy, overrun;

    object_centroid_tracker dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .pixel_valid  (pixel_valid),
        .pixel_rgb    (pixel_rgb),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .centroid_x   (centroid_x),
        .centroid_y   (centroid_y),
        .bbox_x_min   (bbox_x_min),
        .bbox_x_max   (bbox_x_max),
        .bbox_y_min   (bbox_y_min),
        .bbox_y_max   (bbox_y_max),
        .match_count  (match_count),
        .found        (found),
        .result_valid (result_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned exp_cyc;
        int unsigned fnd, cnt, cx, cy, xmin, xmax, ymin, ymax;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int unsigned last_cx = 0, last_cy = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (aresetn === 1'b1 && result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_result_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("latency_cycle", cyc, mon_e.exp_cyc);
                check("found", found, mon_e.fnd);
                check("match_count", match_count, mon_e.cnt);
                check("centroid_x", centroid_x, mon_e.cx);
                check("centroid_y", centroid_y, mon_e.cy);
                check("bbox_x_min", bbox_x_min, mon_e.xmin);
                check("bbox_x_max", bbox_x_max, mon_e.xmax);
                check("bbox_y_min", bbox_y_min, mon_e.ymin);
                check("bbox_y_max", bbox_y_max, mon_e.ymax);
            end
        end
    end

    // All drive tasks start and end on a negedge; each pixel lasts exactly one cycle.
    task automatic px(input int x, input int y, input logic [15:0] rgb, input logic v);
        pixel_valid = v;
        pixel_x     = 11'(x);
        pixel_y     = 11'(y);
        pixel_rgb   = rgb;
        @(negedge clk);
        pixel_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        pixel_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic square(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) px(x, y, Red, 1'b1);
    endtask

    // Drives the frame-end pixel; when pub is set, queues the result it should produce.
    task automatic frame_end(input logic [15:0] rgb, input bit pub, input bit fnd,
                             input int unsigned cnt, input int unsigned xmin,
                             input int unsigned xmax, input int unsigned ymin,
                             input int unsigned ymax, input int unsigned cx,
                             input int unsigned cy);
        exp_t e;
        if (pub) begin
            e.exp_cyc = cyc + (fnd ? 58 : 2);
            e.fnd  = fnd;
            e.cnt  = cnt;
            e.xmin = xmin;
            e.xmax = xmax;
            e.ymin = ymin;
            e.ymax = ymax;
            if (fnd) begin
                last_cx = cx;
                last_cy = cy;
            end
            e.cx = last_cx;
            e.cy = last_cy;
            sb.push_back(e);
        end
        px(639, 479, rgb, 1'b1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("result_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with stimulus toggling.
        repeat (6) begin
            @(negedge clk);
            pixel_valid = ~pixel_valid;
            pixel_rgb   = Red;
            pixel_x     = 11'd639;
            pixel_y     = 11'd479;
        end
        check("rst_centroid_x", centroid_x, 0);
        check("rst_centroid_y", centroid_y, 0);
        check("rst_bbox_x_min", bbox_x_min, 0);
        check("rst_bbox_x_max", bbox_x_max, 0);
        check("rst_bbox_y_min", bbox_y_min, 0);
        check("rst_bbox_y_max", bbox_y_max, 0);
        check("rst_match_count", match_count, 0);
        check("rst_found", found, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        @(negedge clk);
        pixel_valid = 1'b0;
        aresetn = 1'b1;
        idle(20);

        // 10x10 object plus invalid / off-screen red pixels that must be ignored.
        px(200, 10, Red, 1'b0);
        px(640, 10, Red, 1'b1);
        px(10, 480, Red, 1'b1);
        square(100, 109, 50, 59);
        idle(3);
        frame_end(Black, 1, 1, 100, 100, 109, 50, 59, 104, 54);
        idle(2);
        check("busy_during_div", busy, 1);
        wait_drain();
        check("busy_after_pub", busy, 0);

        // 63 pixels: below threshold, centroid holds.
        square(100, 106, 50, 58);
        frame_end(Black, 1, 0, 63, 100, 106, 50, 58, 0, 0);
        wait_drain();

        // Colour window boundaries with single-pixel frames.
        px(5, 7, {5'd20, 6'd20, 5'd10}, 1'b1);
        frame_end(Black, 1, 0, 1, 5, 5, 7, 7, 0, 0);
        wait_drain();
        px(5, 7, {5'd19, 6'd20, 5'd10}, 1'b1);
        frame_end(Black, 1, 0, 0, 2047, 0, 2047, 0, 0, 0);
        wait_drain();
        px(5, 7, {5'd20, 6'd21, 5'd10}, 1'b1);
        frame_end(Black, 1, 0, 0, 2047, 0, 2047, 0, 0, 0);
        wait_drain();
        px(5, 7, {5'd20, 6'd20, 5'd11}, 1'b1);
        frame_end(Black, 1, 0, 0, 2047, 0, 2047, 0, 0, 0);
        wait_drain();
        px(12, 3, {5'd31, 6'd0, 5'd0}, 1'b1);
        frame_end(Black, 1, 0, 1, 12, 12, 3, 3, 0, 0);
        wait_drain();

        // Frame-end pixel itself matches and lifts the count to exactly 64.
        square(100, 106, 50, 58);
        frame_end(Red, 1, 1, 64, 100, 639, 50, 479, 111, 60);
        wait_drain();

        // Back-to-back frames: second frame streams in while the divider runs.
        square(100, 109, 50, 59);
        frame_end(Black, 1, 1, 100, 100, 109, 50, 59, 104, 54);
        square(200, 207, 300, 307);
        frame_end(Black, 1, 1, 64, 200, 207, 300, 307, 203, 303);
        wait_drain();
        check("overrun_clear", overrun, 0);

        // Frame end while busy: flagged, dropped, first result unaffected.
        square(100, 109, 50, 59);
        frame_end(Black, 1, 1, 100, 100, 109, 50, 59, 104, 54);
        idle(5);
        frame_end(Black, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wait_drain();
        idle(70);
        check("overrun_set", overrun, 1);

        // Reset in the middle of the y division, with live accumulation in progress.
        square(100, 109, 50, 59);
        frame_end(Black, 1, 1, 100, 100, 109, 50, 59, 104, 54);
        for (int i = 0; i < 30; i++) px(300 + i, 200, Red, 1'b1);
        idle(10);
        check("busy_in_div_y", busy, 1);
        aresetn = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_centroid_x", centroid_x, 0);
        check("mid_rst_match_count", match_count, 0);
        check("mid_rst_found", found, 0);
        check("mid_rst_overrun", overrun, 0);
        @(negedge clk);
        aresetn = 1'b1;
        last_cx = 0;
        last_cy = 0;
        idle(2);
        square(100, 106, 50, 58);
        frame_end(Red, 1, 1, 64, 100, 639, 50, 479, 111, 60);
        wait_drain();
        idle(10);
        check("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
